watch_edit_ctrl: RTL and testbench

//  Time-setting sequencer for the watch datapath. Turns debounced button levels into

---
 rtl/watch_edit_ctrl_pkg.sv | 20 ++
 rtl/watch_edit_ctrl_if.sv | 27 ++
 rtl/watch_tick_gen.sv | 18 +
 rtl/watch_edit_ctrl.sv | 136 +++++++++++++
 tb/tb_watch_edit_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/watch_edit_ctrl_pkg.sv
// watch_edit_ctrl_pkg: cursor positions, FSM state codes and button bundle for the edit sequencer
package watch_edit_ctrl_pkg;
    typedef logic [1:0] pos_t;
    localparam pos_t POS_MSEC = 2'd0;
    localparam pos_t POS_SEC  = 2'd1;
    localparam pos_t POS_MIN  = 2'd2;
    localparam pos_t POS_HOUR = 2'd3;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } state_e;
    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
    } btn_t;
endpackage

// File: rtl/watch_edit_ctrl_if.sv
// watch_edit_ctrl_if: button/switch levels in, cursor position and edit pulses out
//   i_left/i_right/i_up/i_down : debounced button levels
//   i_edit_en                  : edit-mode request switch
//   o_sel_pos                  : cursor, 0=msec 1=sec 2=min 3=hour
//   o_inc/o_dec                : 1-clk step pulses for the selected field
//   o_edit/o_blink             : edit-mode flag and cursor blink phase
interface watch_edit_ctrl_if;
    import watch_edit_ctrl_pkg::*;
    logic i_left;
    logic i_right;
    logic i_up;
    logic i_down;
    logic i_edit_en;
    pos_t o_sel_pos;
    logic o_inc;
    logic o_dec;
    logic o_edit;
    logic o_blink;
    modport master (
        output i_left, i_right, i_up, i_down, i_edit_en,
        input  o_sel_pos, o_inc, o_dec, o_edit, o_blink
    );
    modport slave (
        input  i_left, i_right, i_up, i_down, i_edit_en,
        output o_sel_pos, o_inc, o_dec, o_edit, o_blink
    );
endinterface

// File: rtl/watch_tick_gen.sv
// watch_tick_gen: free-running divider producing a 1-clk tick every DIV clocks
//   clk, rst : clock and synchronous active-high reset
//   o_tick   : tick pulse
module watch_tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int W = $clog2(DIV + 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign o_tick = cnt_q == LAST;
    assign cnt_d  = o_tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk)
        cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/watch_edit_ctrl.sv
// watch_edit_ctrl: button-to-cursor/step sequencer with hold-to-repeat, edit timeout and blink
//   clk, rst : clock and synchronous active-high reset
//   bus      : button/switch inputs and registered cursor/pulse/edit/blink outputs
module watch_edit_ctrl #(
    parameter int CLK_FREQ         = 100_000_000,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 100,
    parameter int TIMEOUT_MS       = 10_000,
    parameter int BLINK_MS         = 250
) (
    input logic clk,
    input logic rst,
    watch_edit_ctrl_if.slave bus
);
    import watch_edit_ctrl_pkg::*;
    localparam int DIV  = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;
    localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_MS + 1);
    localparam int BW   = $clog2(BLINK_MS + 1);
    localparam logic [RW-1:0] R_MAX  = RW'(RMAX);
    localparam logic [RW-1:0] D_LAST = RW'(REPEAT_DELAY_MS - 1);
    localparam logic [RW-1:0] P_LAST = RW'(REPEAT_PERIOD_MS - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_MS);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_MS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_MS - 1);

    logic tick;
    watch_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .o_tick(tick));

    btn_t   btn_q, btn_p, edge_s;
    state_e state_q, state_d;
    pos_t   sel_q, sel_d;
    logic   up_dir_q, up_dir_d;
    logic   inc_q, inc_d, dec_q, dec_d;
    logic   edit_q, blink_q, blink_d, lock_q, lock_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [TW-1:0] to_q, to_d;
    logic [BW-1:0] bl_q, bl_d;
    logic held, other, rep_hit, to_hit, bl_hit;

    // btn_p forced high in reset: a button held through reset must not look like a fresh press
    always_ff @(posedge clk) begin
        btn_q <= {bus.i_left, bus.i_right, bus.i_up, bus.i_down};
        btn_p <= rst ? '1 : btn_q;
    end

    assign edge_s  = btn_q & ~btn_p;
    assign held    = up_dir_q ? btn_q.up : btn_q.down;
    assign other   = up_dir_q ? btn_q.down : btn_q.up;
    assign rep_hit = tick && rep_q >= ((state_q == ST_HOLD) ? D_LAST : P_LAST);
    assign to_hit  = tick && to_q >= T_LAST;
    assign bl_hit  = tick && bl_q >= B_LAST;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        up_dir_d = up_dir_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        lock_d   = lock_q & bus.i_edit_en;
        rep_d    = (tick && rep_q != R_MAX) ? rep_q + 1'b1 : rep_q;
        case (state_q)
            ST_IDLE: if (bus.i_edit_en && !lock_q) state_d = ST_EDIT;
            ST_EDIT: begin
                rep_d = '0;
                if (edge_s.left && !edge_s.right) sel_d = sel_q + 2'd1;
                else if (edge_s.right && !edge_s.left) sel_d = sel_q - 2'd1;
                if (edge_s.up && !btn_q.down) begin
                    inc_d    = 1'b1;
                    up_dir_d = 1'b1;
                    state_d  = ST_HOLD;
                end else if (edge_s.down && !btn_q.up) begin
                    dec_d    = 1'b1;
                    up_dir_d = 1'b0;
                    state_d  = ST_HOLD;
                end
            end
            default: begin
                if (!held || other) state_d = ST_EDIT;
                else if (rep_hit) begin
                    inc_d   = up_dir_q;
                    dec_d   = !up_dir_q;
                    rep_d   = '0;
                    state_d = ST_REPEAT;
                end
            end
        endcase
        // leaving edit cancels this cycle's actions; a timeout exit arms the lockout
        if (state_q != ST_IDLE && (!bus.i_edit_en || to_hit)) begin
            state_d = ST_IDLE;
            sel_d   = sel_q;
            inc_d   = 1'b0;
            dec_d   = 1'b0;
            lock_d  = bus.i_edit_en;
        end
        to_d    = (state_q == ST_IDLE || state_d == ST_IDLE || |edge_s || inc_d || dec_d) ? '0 :
                  (tick && to_q != T_MAX) ? to_q + 1'b1 : to_q;
        blink_d = (state_d == ST_IDLE) ? 1'b0 : (state_q == ST_IDLE) ? 1'b1 : blink_q ^ bl_hit;
        bl_d    = (state_d == ST_IDLE || state_q == ST_IDLE || bl_hit) ? '0 : bl_q + BW'(tick);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= POS_MSEC;
            up_dir_q <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            edit_q   <= 1'b0;
            blink_q  <= 1'b0;
            lock_q   <= 1'b0;
            rep_q    <= '0;
            to_q     <= '0;
            bl_q     <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            up_dir_q <= up_dir_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            edit_q   <= state_d != ST_IDLE;
            blink_q  <= blink_d;
            lock_q   <= lock_d;
            rep_q    <= rep_d;
            to_q     <= to_d;
            bl_q     <= bl_d;
        end
    end

    assign bus.o_sel_pos = sel_q;
    assign bus.o_inc     = inc_q;
    assign bus.o_dec     = dec_q;
    assign bus.o_edit    = edit_q;
    assign bus.o_blink   = blink_q;
endmodule

// File: tb/tb_watch_edit_ctrl.sv
// tb_watch_edit_ctrl: scoreboard bench for the edit sequencer (1 ms tick per clock)
module tb_watch_edit_ctrl;
    localparam int D = 5;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    watch_edit_ctrl_if ifc();
    watch_edit_ctrl #(
        .CLK_FREQ(1000), .REPEAT_DELAY_MS(D), .REPEAT_PERIOD_MS(P), .TIMEOUT_MS(20), .BLINK_MS(3)
    ) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0;
    int nchk = 0;
    int sel_m = 0;
    int sbq[$];
    int e;
    int c;

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // expected pulses are encoded as cycle*2 + (1 for o_inc, 0 for o_dec)
    always @(negedge clk) begin
        if (ifc.o_inc || ifc.o_dec) begin
            chk("inc_dec_excl", int'(ifc.o_inc & ifc.o_dec), 0);
            if (sbq.size() == 0) chk("spurious_pulse_cyc", cyc, -1);
            else begin
                e = sbq.pop_front();
                chk("pulse_cyc", cyc, e / 2);
                chk("pulse_is_inc", int'(ifc.o_inc), e % 2);
            end
        end
    end

    task automatic enter_edit();
        @(negedge clk);
        ifc.i_edit_en = 1'b0;
        repeat (2) @(negedge clk);
        ifc.i_edit_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("edit_entry", int'(ifc.o_edit), 1);
        chk("blink_entry", int'(ifc.o_blink), 1);
    endtask

    task automatic tap(input bit l, input bit r);
        @(negedge clk);
        ifc.i_left  = l;
        ifc.i_right = r;
        @(negedge clk);
        ifc.i_left  = 1'b0;
        ifc.i_right = 1'b0;
        repeat (2) @(negedge clk);
        if (l && !r) sel_m = (sel_m + 1) % 4;
        else if (r && !l) sel_m = (sel_m + 3) % 4;
        chk("sel", int'(ifc.o_sel_pos), sel_m);
    endtask

    task automatic move_to(input int p);
        while (sel_m != p) tap(1'b1, 1'b0);
    endtask

    // first pulse 2 clocks after the press, then D ticks, then every P ticks while held
    task automatic press(input bit up, input int n);
        int t0;
        @(negedge clk);
        t0 = cyc;
        if (up) ifc.i_up = 1'b1;
        else ifc.i_down = 1'b1;
        sbq.push_back((t0 + 2) * 2 + int'(up));
        for (int t = t0 + 2 + D; t <= t0 + n + 1; t += P) sbq.push_back(t * 2 + int'(up));
        repeat (n) @(negedge clk);
        ifc.i_up   = 1'b0;
        ifc.i_down = 1'b0;
        repeat (6) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"}, int'(ifc.o_sel_pos), 0);
        chk({tag, "_inc"}, int'(ifc.o_inc), 0);
        chk({tag, "_dec"}, int'(ifc.o_dec), 0);
        chk({tag, "_edit"}, int'(ifc.o_edit), 0);
        chk({tag, "_blink"}, int'(ifc.o_blink), 0);
    endtask

    initial begin
        ifc.i_left = 1'b0; ifc.i_right = 1'b0; ifc.i_up = 1'b0; ifc.i_down = 1'b0;
        ifc.i_edit_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        // cursor movement and wrap
        enter_edit();
        repeat (4) tap(1'b1, 1'b0);
        tap(1'b0, 1'b1);
        // hold-to-repeat, both directions
        enter_edit();
        tap(1'b0, 1'b1);
        press(1'b1, 12);
        press(1'b0, 8);
        // simultaneous up/down and left/right
        enter_edit();
        @(negedge clk);
        ifc.i_up = 1'b1; ifc.i_down = 1'b1;
        repeat (10) @(negedge clk);
        ifc.i_up = 1'b0; ifc.i_down = 1'b0;
        repeat (3) @(negedge clk);
        tap(1'b1, 1'b1);
        // inactivity timeout, blink phase, lockout
        @(negedge clk);
        ifc.i_edit_en = 1'b0;
        repeat (2) @(negedge clk);
        ifc.i_edit_en = 1'b1;
        c = cyc;
        repeat (4) @(negedge clk);
        chk("blink_toggle0", int'(ifc.o_blink), 0);
        repeat (3) @(negedge clk);
        chk("blink_toggle1", int'(ifc.o_blink), 1);
        repeat (13) @(negedge clk);
        chk("pre_timeout_edit", int'(ifc.o_edit), 1);
        @(negedge clk);
        chk("timeout_cyc", cyc - c, 21);
        chk("timeout_edit", int'(ifc.o_edit), 0);
        chk("timeout_blink", int'(ifc.o_blink), 0);
        repeat (30) @(negedge clk);
        chk("lockout_edit", int'(ifc.o_edit), 0);
        chk("sel_kept_idle", int'(ifc.o_sel_pos), sel_m);
        enter_edit();
        // reset in the middle of auto-repeat
        move_to(3);
        @(negedge clk);
        c = cyc;
        ifc.i_up = 1'b1;
        sbq.push_back((c + 2) * 2 + 1);
        sbq.push_back((c + 2 + D) * 2 + 1);
        sbq.push_back((c + 2 + D + P) * 2 + 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrpt_rst");
        sel_m = 0;
        rst = 1'b0;
        chk("rst_sb_drain", sbq.size(), 0);
        repeat (12) @(negedge clk);
        chk("edit_after_rst", int'(ifc.o_edit), 1);
        ifc.i_up = 1'b0;
        repeat (2) @(negedge clk);
        press(1'b1, 1);
        // edit disable during hold
        enter_edit();
        move_to(1);
        @(negedge clk);
        c = cyc;
        ifc.i_down = 1'b1;
        sbq.push_back((c + 2) * 2);
        repeat (3) @(negedge clk);
        ifc.i_edit_en = 1'b0;
        @(negedge clk);
        chk("hold_exit_edit", int'(ifc.o_edit), 0);
        chk("hold_exit_sel", int'(ifc.o_sel_pos), sel_m);
        repeat (10) @(negedge clk);
        ifc.i_down = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_sb_drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
